// File: rtl/vga_sync_timer.sv
// rtl/vga_sync_timer.sv - 640x480@60 Hz VGA timing generator with frame-locked blink
//
// Purpose:
//   Divides the system clock down to the pixel rate, walks a horizontal and
//   vertical raster counter, and produces registered sync / active-video
//   decodes aligned with the exported coordinates. A frame counter derives
//   the cursor blink square wave used by the character generator.
//
// Ports:
//   clk          in   1   system clock (100 MHz nominal)
//   reset_n      in   1   asynchronous active-low reset
//   pixel_x      out  10  horizontal count, 0..H_TOTAL-1
//   pixel_y      out  10  vertical count, 0..V_TOTAL-1
//   hsync        out  1   horizontal sync, active low
//   vsync        out  1   vertical sync, active low
//   video_on     out  1   high inside the visible area
//   p_tick       out  1   one-clk strobe in the last clk of each pixel period
//   frame_start  out  1   one-clk strobe on the clk counters move to (0,0)
//   parpadeo     out  1   blink square wave, toggles every BLINK_FRAMES frames

module vga_sync_timer #(
  parameter int TICK_DIV     = 4,
  parameter int H_DISPLAY    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_DISPLAY    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_start,
  output logic       parpadeo
);

  // ---------------------------------------------------------------------------
  // Derived timing constants
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0]  tick_cnt;
  logic [9:0]         h_cnt;
  logic [9:0]         v_cnt;
  logic [FRAME_W-1:0] frame_cnt;

  // Next-state raster position, used both to advance the counters and to
  // pre-compute the sync decodes so they land on the same edge.
  logic [9:0]         h_next;
  logic [9:0]         v_next;
  logic               h_at_end;
  logic               v_at_end;
  logic [TICK_W-1:0]  tick_next;

  // ---------------------------------------------------------------------------
  // Combinational next-state and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    tick_next = (tick_cnt >= TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
  end

  always_comb begin
    h_at_end = (h_cnt == H_LAST);
    v_at_end = (v_cnt == V_LAST);

    // Anything at or past the last column (including unreachable values
    // after an upset) folds back to column 0.
    if (h_cnt >= H_LAST) begin
      h_next = '0;
    end else begin
      h_next = h_cnt + 10'd1;
    end

    // The line counter advances only at the end of a line; an out-of-range
    // value is cleared on the next pixel tick regardless of column.
    v_next = v_cnt;
    if (v_cnt > V_LAST) begin
      v_next = '0;
    end else if (h_at_end) begin
      v_next = v_at_end ? '0 : v_cnt + 10'd1;
    end
  end

  always_comb begin
    p_tick      = (tick_cnt == TICK_LAST);
    frame_start = p_tick & h_at_end & v_at_end;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt  <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
      // Decodes start out describing position (0,0).
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      video_on  <= 1'b1;
      parpadeo  <= 1'b0;
    end else begin
      tick_cnt <= tick_next;

      if (p_tick) begin
        h_cnt    <= h_next;
        v_cnt    <= v_next;
        hsync    <= ~((h_next >= HS_START) && (h_next <= HS_END));
        vsync    <= ~((v_next >= VS_START) && (v_next <= VS_END));
        video_on <= (h_next < H_VIS) && (v_next < V_VIS);
      end

      // Blink phase only moves on frame boundaries, so the cursor never
      // changes state partway down the screen.
      if (frame_start) begin
        if (frame_cnt >= FRAME_LAST) begin
          frame_cnt <= '0;
          parpadeo  <= ~parpadeo;
        end else begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
      end
    end
  end

  // Coordinates come straight from the counters; each value is stable for
  // TICK_DIV clks, which covers the one-clk font ROM latency downstream.
  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;

endmodule
